digi_scan_decoder: RTL
======================

// Module: digi_scan_decoder
// PURPOSE
//  Receive-side counterpart of the multiplexed 4-digit LED scan driver: samples the
//  scanned bus (segments + active-low digit select), decodes each digit's 7-seg
//  pattern back to BCD, and publishes all four digits atomically once per full scan frame.
//  Used for display loopback self-check and for board-level capture of a scanned display.
// PARAMETERS
//  STABLE_CNT  1  consecutive identical samples of {digit,Seg} required to accept a digit (1..15)
//  CNT_W       4  width of the stability counter; must hold STABLE_CNT
// PORTS
//  Clk         in   1   system clock, rising edge
//  Reset_N     in   1   asynchronous reset, active low
//  Seg         in   8   segment bus, active high; Seg[0]=a..Seg[6]=g, Seg[7]=dp
//  Sl          in   4   digit select, active low, one-cold; Sl[k]=0 selects digit k
//  Digits      out  16  decoded frame; Digits[4k+3:4k]=digit k; 4'hF = blank digit
//  Dp          out  4   decimal-point state per digit, frame-aligned with Digits
//  Frame_Done  out  1   one-cycle pulse when Digits/Dp are updated
//  Err         out  1   one-cycle pulse on illegal select or undecodable pattern
//  Locked      out  1   high while FSM is in S_ACQ
// BEHAVIOUR
//  Reset: Digits=16'hFFFF, Dp=0, Frame_Done=0, Err=0, Locked=0; seen mask, shadow regs,
//   stability counter cleared; FSM=S_SYNC. Reset mid-frame discards the partial frame.
//  Input path: Seg and Sl pass through two flops (sync stages) before any use.
//  Sample classification (synced values):
//   - Sl one-cold: valid sample, index k.
//   - Sl=4'hF: idle/blank gap; stability counter cleared; no error.
//   - any other Sl (two or more zeros): Err pulse, counter cleared, seen cleared, FSM->S_SYNC.
//  Stability: counter increments (saturating at STABLE_CNT) while {k,Seg} equals previous
//   sample, else reloads to 1. Digit accepted in the cycle the counter first reaches
//   STABLE_CNT; exactly one acceptance per run of identical samples.
//  Decode of Seg[6:0] (gfedcba): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D or 7C->6,
//   07->7, 7F->8, 6F or 67->9, 00->F (blank). Any other pattern: undecodable.
//  FSM:
//   - S_SYNC: ignore accepted digits except k=0 with decodable pattern; that acceptance
//     writes shadow[0], sets seen=4'b0001, goes to S_ACQ.
//   - S_ACQ: accepted decodable digit k writes shadow[k], Dp shadow[k]=Seg[7], sets seen[k];
//     re-acceptance of an already-seen digit overwrites its shadow (no error).
//     Undecodable pattern: Err pulse, seen cleared, -> S_SYNC.
//     Next-seen==4'hF: same cycle load Digits/Dp from shadow (incl. current digit),
//     pulse Frame_Done, clear seen, stay in S_ACQ; next frame may start at any digit.
//  Simultaneous events: Err has priority; never Frame_Done and Err in same cycle.
//  Latency: Seg/Sl at pins -> acceptance = 2 + STABLE_CNT clocks; Frame_Done coincides
//   with acceptance of the fourth distinct digit; Digits valid from that cycle.
//  Digits/Dp hold last completed frame until the next Frame_Done or reset.
// TESTING
//  1 Scan driver loop, STABLE_CNT=1: Sl 1110/1101/1011/0111 with 8,2,1,7 patterns (7F,5B,06,07)
//    repeating each clock -> first Frame_Done 2+1 clocks after digit 3 appears; Digits=16'h7128,
//    Frame_Done every 4 clocks thereafter, Err never, Locked=1 after first digit 0.
//  2 STABLE_CNT=3, each digit held 2 clocks -> no acceptance, no Frame_Done; hold 3 clocks ->
//    frames complete, Digits correct; hold 8 clocks -> still one acceptance per digit.
//  3 Inject Sl=4'b1100 mid-frame -> Err pulse one cycle, Locked=0, Digits unchanged; resumes
//    only after digit 0 accepted; next Frame_Done carries only post-error data.
//  4 Digit 2 driven with Seg=8'h49 -> Err pulse, -> S_SYNC; blank (8'h00) on digit 1 with dp set
//    (8'h80) -> Digits[7:4]=4'hF, Dp[1]=1, no Err.
//  5 Reset_N low for 1 clock mid-frame (after digits 0,1) -> outputs at reset values
//    immediately (async); after release, first Frame_Done only after full new frame from digit 0.
//  6 Sl=4'hF gaps inserted between digits -> no Err, frame completes, Digits correct; 6/9 tail-less
//    patterns 7C/67 decode to 6/9.

Source files
------------

// File: rtl/digi_scan_decoder.sv
// digi_scan_decoder: recovers BCD digits from a multiplexed 4-digit 7-seg scan bus, publishing whole frames atomically
// Ports: clk_i clock; rst_ni async active-low reset; seg_i segments {dp,g..a}; sl_i active-low one-cold digit select;
//        digits_o 4 BCD nibbles (F=blank); dp_o decimal points; frame_done_o frame-update pulse; err_o error pulse;
//        locked_o high while acquiring frames
module digi_scan_decoder #(
  parameter int STABLE_CNT = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  seg_i,
  input  logic [3:0]  sl_i,
  output logic [15:0] digits_o,
  output logic [3:0]  dp_o,
  output logic        frame_done_o,
  output logic        err_o,
  output logic        locked_o
);
  typedef enum logic {S_SYNC, S_ACQ} state_e;
  localparam logic [CNT_W-1:0] STB = CNT_W'(STABLE_CNT);
  state_e state_q, state_d;
  logic [7:0] seg_s1_q, seg_s2_q, prev_seg_q;
  logic [3:0] sl_s1_q, sl_s2_q;
  logic [1:0] prev_k_q, k;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] seen_q, seen_d, seen_nx, dp_sh_q, dp_sh_d, dp_q, dp_d;
  logic [15:0] shadow_q, shadow_d, digits_q, digits_d;
  logic fd_q, fd_d, err_q, err_d;
  logic valid, gap, same, accept, ok;
  logic [3:0] val;
  function automatic logic [4:0] dec(input logic [6:0] p);
    case (p)
      7'h3F:        dec = 5'h10;
      7'h06:        dec = 5'h11;
      7'h5B:        dec = 5'h12;
      7'h4F:        dec = 5'h13;
      7'h66:        dec = 5'h14;
      7'h6D:        dec = 5'h15;
      7'h7D, 7'h7C: dec = 5'h16;
      7'h07:        dec = 5'h17;
      7'h7F:        dec = 5'h18;
      7'h6F, 7'h67: dec = 5'h19;
      7'h00:        dec = 5'h1F;
      default:      dec = 5'h00;
    endcase
  endfunction
  always_comb begin
    valid = (sl_s2_q == 4'b1110) || (sl_s2_q == 4'b1101) || (sl_s2_q == 4'b1011) || (sl_s2_q == 4'b0111);
    gap = sl_s2_q == 4'hF;
    k = !sl_s2_q[0] ? 2'd0 : !sl_s2_q[1] ? 2'd1 : !sl_s2_q[2] ? 2'd2 : 2'd3;
    {ok, val} = dec(seg_s2_q[6:0]);
    // a cleared counter means no prior sample to match (after reset, gap or error)
    same = (cnt_q != '0) && (k == prev_k_q) && (seg_s2_q == prev_seg_q);
    cnt_d = !valid ? '0 : !same ? CNT_W'(1) : (cnt_q == STB) ? cnt_q : cnt_q + CNT_W'(1);
    // fire only on the transition into STB so a long run accepts once
    accept = valid && (cnt_d == STB) && !(same && cnt_q == STB);
    seen_nx = seen_q | (4'b0001 << k);
  end
  always_comb begin
    state_d = state_q;
    seen_d = seen_q;
    shadow_d = shadow_q;
    dp_sh_d = dp_sh_q;
    digits_d = digits_q;
    dp_d = dp_q;
    fd_d = 1'b0;
    err_d = 1'b0;
    if (!valid && !gap) begin
      err_d = 1'b1;
      seen_d = '0;
      state_d = S_SYNC;
    end else if (accept) begin
      if (state_q == S_SYNC) begin
        if (k == 2'd0 && ok) begin
          shadow_d[3:0] = val;
          dp_sh_d[0] = seg_s2_q[7];
          seen_d = 4'b0001;
          state_d = S_ACQ;
        end
      end else if (!ok) begin
        err_d = 1'b1;
        seen_d = '0;
        state_d = S_SYNC;
      end else begin
        shadow_d[4*k +: 4] = val;
        dp_sh_d[k] = seg_s2_q[7];
        seen_d = seen_nx;
        if (seen_nx == 4'hF) begin
          digits_d = shadow_d;
          dp_d = dp_sh_d;
          fd_d = 1'b1;
          seen_d = '0;
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      sl_s1_q <= 4'hF;
      sl_s2_q <= 4'hF;
      prev_seg_q <= '0;
      prev_k_q <= '0;
      cnt_q <= '0;
      state_q <= S_SYNC;
      seen_q <= '0;
      shadow_q <= 16'hFFFF;
      dp_sh_q <= '0;
      digits_q <= 16'hFFFF;
      dp_q <= '0;
      fd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      seg_s1_q <= seg_i;
      seg_s2_q <= seg_s1_q;
      sl_s1_q <= sl_i;
      sl_s2_q <= sl_s1_q;
      if (valid) begin
        prev_seg_q <= seg_s2_q;
        prev_k_q <= k;
      end
      cnt_q <= cnt_d;
      state_q <= state_d;
      seen_q <= seen_d;
      shadow_q <= shadow_d;
      dp_sh_q <= dp_sh_d;
      digits_q <= digits_d;
      dp_q <= dp_d;
      fd_q <= fd_d;
      err_q <= err_d;
    end
  end
  assign digits_o = digits_q;
  assign dp_o = dp_q;
  assign frame_done_o = fd_q;
  assign err_o = err_q;
  assign locked_o = state_q == S_ACQ;
endmodule
